ime_fetch: RTL and testbench



---
 rtl/ime_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_ime_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ime_fetch.sv
// IME search-window fetch: fills a 3-MB-wide x SW_H-row window from external
// memory (full or one-column incremental), then serves 48-pixel rows on demand.
module ime_fetch #(
    parameter int BIT_DEPTH    = 8,
    parameter int SW_H         = 48,
    parameter int SW_H_LEN     = 6,
    parameter int PIC_W_MB_LEN = 8,
    parameter int PIC_H_MB_LEN = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIC_W_MB_LEN-1:0]     sysif_total_x_i,
    input  logic [PIC_H_MB_LEN-1:0]     sysif_total_y_i,
    input  logic                        fetchif_start_i,
    input  logic [PIC_W_MB_LEN-1:0]     fetchif_mb_x_i,
    input  logic [PIC_H_MB_LEN-1:0]     fetchif_mb_y_i,
    output logic                        fetchif_valid_o,
    input  logic                        fetchif_load_i,
    input  logic [SW_H_LEN-1:0]         fetchif_addr_i,
    output logic [48*BIT_DEPTH-1:0]     fetchif_data_o,
    output logic                        ext_req_o,
    output logic [PIC_W_MB_LEN-1:0]     ext_x_o,
    output logic [PIC_H_MB_LEN+3:0]     ext_y_o,
    input  logic                        ext_ack_i,
    input  logic [16*BIT_DEPTH-1:0]     ext_data_i
);

    localparam int WORD_W = 16 * BIT_DEPTH;
    localparam int XW     = PIC_W_MB_LEN + 2;
    localparam int YW     = PIC_H_MB_LEN + 5;

    localparam logic signed [XW-1:0] X_ONE     = XW'(1);
    localparam logic signed [YW-1:0] Y_SIXTEEN = YW'(16);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    // Modulo-3 bank arithmetic (b and n are both in 0..2).
    function automatic logic [1:0] bank_add(input logic [1:0] b, input logic [1:0] n);
        logic [2:0] s;
        s = {1'b0, b} + {1'b0, n};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Column index mb_x-1+col, clamped to the picture [0, total_x].
    function automatic logic [PIC_W_MB_LEN-1:0] clamp_x(input logic [PIC_W_MB_LEN-1:0] mb_x,
                                                        input logic [1:0]              col,
                                                        input logic [PIC_W_MB_LEN-1:0] tot);
        logic signed [XW-1:0] v;
        v = $signed({2'b00, mb_x}) + $signed({{(XW-2){1'b0}}, col}) - X_ONE;
        if (v < 0)
            return '0;
        else if (v > $signed({2'b00, tot}))
            return tot;
        else
            return v[PIC_W_MB_LEN-1:0];
    endfunction

    // Pixel row mb_y*16-16+row, clamped to the picture [0, total_y*16+15].
    function automatic logic [YW-2:0] clamp_y(input logic [PIC_H_MB_LEN-1:0] mb_y,
                                              input logic [SW_H_LEN-1:0]     row,
                                              input logic [PIC_H_MB_LEN-1:0] tot);
        logic signed [YW-1:0] v;
        logic signed [YW-1:0] hi;
        v  = $signed({1'b0, mb_y, 4'b0000}) - Y_SIXTEEN
           + $signed({{(YW-SW_H_LEN){1'b0}}, row});
        hi = $signed({1'b0, tot, 4'b1111});
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi[YW-2:0];
        else
            return v[YW-2:0];
    endfunction

    state_t                    r_state;
    logic [1:0]                r_left_bank;
    logic                      r_primed;
    logic                      r_full;
    logic [1:0]                r_col;
    logic [SW_H_LEN-1:0]       r_row;
    logic [PIC_W_MB_LEN-1:0]   r_mb_x;
    logic [PIC_W_MB_LEN-1:0]   r_total_x;
    logic [PIC_H_MB_LEN-1:0]   r_mb_y;
    logic [PIC_H_MB_LEN-1:0]   r_total_y;
    logic [WORD_W-1:0]         r_bank [3][SW_H];

    logic                      w_start;
    logic                      w_ack;
    logic                      w_last_row;
    logic                      w_last;
    logic                      w_full_req;
    logic [1:0]                w_wr_bank;
    logic [1:0]                w_nxt_col;
    logic [SW_H_LEN-1:0]       w_nxt_row;
    logic [PIC_W_MB_LEN-1:0]   w_src_x;
    logic [PIC_W_MB_LEN-1:0]   w_src_tx;
    logic [PIC_H_MB_LEN-1:0]   w_src_y;
    logic [PIC_H_MB_LEN-1:0]   w_src_ty;
    logic [PIC_W_MB_LEN-1:0]   w_nxt_x;
    logic [PIC_H_MB_LEN+3:0]   w_nxt_y;

    assign w_start    = (r_state == IDLE) && fetchif_start_i;
    assign w_ack      = (r_state == LOAD) && ext_req_o && ext_ack_i;
    assign w_last_row = (r_row == SW_H_LEN'(SW_H - 1));
    assign w_last     = w_ack && w_last_row && (r_col == 2'd2);

    // A full reload is needed unless this MB is the right-hand neighbour of the last one.
    assign w_full_req = (fetchif_mb_x_i == '0) || !r_primed
                     || (fetchif_mb_y_i != r_mb_y)
                     || ({1'b0, fetchif_mb_x_i} != ({1'b0, r_mb_x} + 1'b1));

    // Incremental loads overwrite the outgoing left column, which then becomes the right one.
    assign w_wr_bank  = r_full ? bank_add(r_left_bank, r_col) : r_left_bank;

    // Next word position and the operands its address is derived from.
    always_comb begin
        w_nxt_row = r_row;
        w_nxt_col = r_col;
        w_src_x   = r_mb_x;
        w_src_y   = r_mb_y;
        w_src_tx  = r_total_x;
        w_src_ty  = r_total_y;
        if (w_start) begin
            w_nxt_row = '0;
            w_nxt_col = w_full_req ? 2'd0 : 2'd2;
            w_src_x   = fetchif_mb_x_i;
            w_src_y   = fetchif_mb_y_i;
            w_src_tx  = sysif_total_x_i;
            w_src_ty  = sysif_total_y_i;
        end else if (w_ack && !w_last) begin
            if (w_last_row) begin
                w_nxt_row = '0;
                w_nxt_col = r_col + 2'd1;
            end else begin
                w_nxt_row = r_row + SW_H_LEN'(1);
            end
        end
        w_nxt_x = clamp_x(w_src_x, w_nxt_col, w_src_tx);
        w_nxt_y = clamp_y(w_src_y, w_nxt_row, w_src_ty);
    end

    // Control FSM with registered request/address/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_left_bank     <= 2'd0;
            r_primed        <= 1'b0;
            r_full          <= 1'b0;
            r_col           <= 2'd0;
            r_row           <= '0;
            fetchif_valid_o <= 1'b0;
            ext_req_o       <= 1'b0;
            ext_x_o         <= '0;
            ext_y_o         <= '0;
        end else begin
            fetchif_valid_o <= 1'b0;
            r_col           <= w_nxt_col;
            r_row           <= w_nxt_row;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state   <= LOAD;
                        r_full    <= w_full_req;
                        ext_req_o <= 1'b1;
                        ext_x_o   <= w_nxt_x;
                        ext_y_o   <= w_nxt_y;
                    end
                end
                LOAD: begin
                    if (w_ack) begin
                        ext_x_o <= w_nxt_x;
                        ext_y_o <= w_nxt_y;
                    end
                    if (w_last) begin
                        r_state         <= DONE;
                        ext_req_o       <= 1'b0;
                        fetchif_valid_o <= 1'b1;
                        r_primed        <= 1'b1;
                        if (!r_full) r_left_bank <= bank_add(r_left_bank, 2'd1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request operands captured at start; kept across reset for the next-MB comparison.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_mb_x    <= fetchif_mb_x_i;
            r_mb_y    <= fetchif_mb_y_i;
            r_total_x <= sysif_total_x_i;
            r_total_y <= sysif_total_y_i;
        end
    end

    // Window storage: each accepted external word lands in its column bank.
    always_ff @(posedge clk) begin
        if (w_ack) r_bank[w_wr_bank][r_row] <= ext_data_i;
    end

    // Row read port, {right, centre, left}; ignored while a load is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchif_data_o <= '0;
        end else if (fetchif_load_i && (r_state != LOAD)) begin
            if (int'(fetchif_addr_i) >= SW_H)
                fetchif_data_o <= '0;
            else
                fetchif_data_o <= {r_bank[bank_add(r_left_bank, 2'd2)][fetchif_addr_i],
                                   r_bank[bank_add(r_left_bank, 2'd1)][fetchif_addr_i],
                                   r_bank[r_left_bank][fetchif_addr_i]};
        end
    end

endmodule

// File: tb/tb_ime_fetch.sv
// Directed bench for ime_fetch: full/incremental loads, clamps, backpressure,
// reset abort, ignored events and row reads against a pixel-pattern memory.
module tb_ime_fetch;

    localparam int SWH = 48;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   sysif_total_x_i;
    logic [7:0]   sysif_total_y_i;
    logic         fetchif_start_i;
    logic [7:0]   fetchif_mb_x_i;
    logic [7:0]   fetchif_mb_y_i;
    logic         fetchif_valid_o;
    logic         fetchif_load_i;
    logic [5:0]   fetchif_addr_i;
    logic [383:0] fetchif_data_o;
    logic         ext_req_o;
    logic [7:0]   ext_x_o;
    logic [11:0]  ext_y_o;
    logic         ext_ack_i;
    logic [127:0] ext_data_i;

    int n_vec = 0;
    int n_bad = 0;
    int tx = 3;
    int ty = 2;
    logic [383:0] last_exp;

    ime_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .sysif_total_x_i (sysif_total_x_i),
        .sysif_total_y_i (sysif_total_y_i),
        .fetchif_start_i (fetchif_start_i),
        .fetchif_mb_x_i  (fetchif_mb_x_i),
        .fetchif_mb_y_i  (fetchif_mb_y_i),
        .fetchif_valid_o (fetchif_valid_o),
        .fetchif_load_i  (fetchif_load_i),
        .fetchif_addr_i  (fetchif_addr_i),
        .fetchif_data_o  (fetchif_data_o),
        .ext_req_o       (ext_req_o),
        .ext_x_o         (ext_x_o),
        .ext_y_o         (ext_y_o),
        .ext_ack_i       (ext_ack_i),
        .ext_data_i      (ext_data_i)
    );

    always #5 clk = ~clk;

    // External picture memory: every pixel is a function of its (MB column, row).
    function automatic logic [127:0] word_of(input int x, input int y);
        logic [127:0] w;
        for (int p = 0; p < 16; p++) w[p*8 +: 8] = 8'((x * 53 + y * 7 + p * 3) & 255);
        return w;
    endfunction

    assign ext_data_i = word_of(int'(ext_x_o), int'(ext_y_o));

    function automatic int cx(input int mbx, input int c);
        int v;
        v = mbx - 1 + c;
        if (v < 0) v = 0;
        if (v > tx) v = tx;
        return v;
    endfunction

    function automatic int cy(input int mby, input int r);
        int v;
        v = mby * 16 - 16 + r;
        if (v < 0) v = 0;
        if (v > ty * 16 + 15) v = ty * 16 + 15;
        return v;
    endfunction

    function automatic logic [383:0] exp_row(input int mbx, input int mby, input int a);
        if (a >= SWH) return '0;
        return {word_of(cx(mbx, 2), cy(mby, a)), word_of(cx(mbx, 1), cy(mby, a)),
                word_of(cx(mbx, 0), cy(mby, a))};
    endfunction

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One load with ack on every period-th cycle; exp_lat=0 skips the latency check.
    task automatic do_load(input int mbx, input int mby, input bit full, input int period,
                           input int exp_lat);
        int k, n, nw, c, r;
        nw = full ? 3 * SWH : SWH;
        @(posedge clk); #1;
        fetchif_start_i = 1'b1;
        fetchif_mb_x_i  = 8'(mbx);
        fetchif_mb_y_i  = 8'(mby);
        ext_ack_i       = 1'b1;
        @(posedge clk); #1;
        fetchif_start_i = 1'b0;
        k = 0;
        n = 0;
        while (fetchif_valid_o !== 1'b1 && n < 1000) begin
            ext_ack_i = ((n % period) == period - 1);
            @(negedge clk);
            if (k < nw) begin
                c = full ? k / SWH : 2;
                r = k % SWH;
                chk("req_high", 384'(ext_req_o), 384'(1));
                chk("ext_x", 384'(ext_x_o), 384'(cx(mbx, c)));
                chk("ext_y", 384'(ext_y_o), 384'(cy(mby, r)));
            end else begin
                chk("req_extra", 384'(ext_req_o), 384'(0));
            end
            if (ext_ack_i && ext_req_o) k++;
            @(posedge clk); #1;
            n++;
        end
        ext_ack_i = 1'b0;
        chk("valid", 384'(fetchif_valid_o), 384'(1));
        chk("words", 384'(k), 384'(nw));
        if (exp_lat != 0) chk("latency", 384'(n + 1), 384'(exp_lat));
        chk("req_in_done", 384'(ext_req_o), 384'(0));
        // A start that coincides with DONE must not launch a load.
        fetchif_start_i = 1'b1;
        @(posedge clk); #1;
        fetchif_start_i = 1'b0;
        chk("valid_one_cycle", 384'(fetchif_valid_o), 384'(0));
        chk("start_in_done", 384'(ext_req_o), 384'(0));
    endtask

    task automatic rd(input string tag, input int addr, input logic [383:0] exp);
        @(posedge clk); #1;
        fetchif_load_i = 1'b1;
        fetchif_addr_i = 6'(addr);
        @(posedge clk); #1;
        fetchif_load_i = 1'b0;
        chk(tag, fetchif_data_o, exp);
        last_exp = exp;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        sysif_total_x_i = 8'(tx);
        sysif_total_y_i = 8'(ty);
        fetchif_start_i = 1'b0;
        fetchif_mb_x_i  = '0;
        fetchif_mb_y_i  = '0;
        fetchif_load_i  = 1'b0;
        fetchif_addr_i  = '0;
        ext_ack_i       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 384'(fetchif_valid_o), 384'(0));
        chk("rst_req", 384'(ext_req_o), 384'(0));
        chk("rst_x", 384'(ext_x_o), 384'(0));
        chk("rst_y", 384'(ext_y_o), 384'(0));
        chk("rst_data", fetchif_data_o, 384'(0));
        rst = 1'b0;

        // Scenario 1: full load at the picture origin.
        do_load(0, 0, 1'b1, 1, 145);
        rd("s1_addr0", 0, {word_of(1, 0), word_of(0, 0), word_of(0, 0)});
        rd("s1_addr47", 47, {word_of(1, 31), word_of(0, 31), word_of(0, 31)});
        rd("s1_addr48", 48, 384'(0));
        rd("s1_addr63", 63, 384'(0));

        // Scenario 2: incremental load of column 2.
        do_load(1, 0, 1'b0, 1, 49);
        rd("s2_addr16", 16, {word_of(2, 0), word_of(1, 0), word_of(0, 0)});
        repeat (2) @(posedge clk);
        #1;
        chk("s2_hold", fetchif_data_o, last_exp);

        // Scenario 4: incremental load under ack backpressure.
        do_load(2, 0, 1'b0, 3, 145);
        rd("s4_addr30", 30, {word_of(3, 14), word_of(2, 14), word_of(1, 14)});

        // Scenario 3: right-edge clamp, then bottom clamp via a full load.
        do_load(3, 0, 1'b0, 1, 49);
        rd("s3_addr20", 20, {word_of(3, 4), word_of(3, 4), word_of(2, 4)});
        do_load(3, 2, 1'b1, 1, 145);
        rd("s3_addr40", 40, {word_of(3, 47), word_of(3, 47), word_of(2, 47)});
        rd("s3_addr10", 10, {word_of(3, 26), word_of(3, 26), word_of(2, 26)});
        chk("s3_model_row", last_exp, exp_row(3, 2, 10));

        // Scenario 5: reset aborts a load; stray start/load during LOAD are ignored.
        @(posedge clk); #1;
        fetchif_start_i = 1'b1;
        fetchif_mb_x_i  = 8'd1;
        fetchif_mb_y_i  = 8'd2;
        @(posedge clk); #1;
        fetchif_start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ext_ack_i = 1'b1;
            if (i == 4) begin
                fetchif_start_i = 1'b1;
                fetchif_mb_x_i  = 8'd0;
                fetchif_load_i  = 1'b1;
                fetchif_addr_i  = 6'd5;
            end
            @(negedge clk);
            chk("s5_x", 384'(ext_x_o), 384'(cx(1, 0)));
            chk("s5_y", 384'(ext_y_o), 384'(cy(2, i)));
            @(posedge clk); #1;
            fetchif_start_i = 1'b0;
            fetchif_load_i  = 1'b0;
            fetchif_mb_x_i  = 8'd1;
        end
        ext_ack_i = 1'b0;
        chk("s5_req_mid", 384'(ext_req_o), 384'(1));
        chk("s5_data_hold", fetchif_data_o, last_exp);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("s5_req_after_rst", 384'(ext_req_o), 384'(0));
        chk("s5_x_after_rst", 384'(ext_x_o), 384'(0));
        chk("s5_y_after_rst", 384'(ext_y_o), 384'(0));
        chk("s5_data_after_rst", fetchif_data_o, 384'(0));
        do_load(2, 2, 1'b1, 1, 145);
        rd("s5_addr40", 40, {word_of(3, 47), word_of(2, 47), word_of(1, 47)});
        rd("s5_addr0", 0, exp_row(2, 2, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
